// File: rtl/regfile_scan_unit.sv
// ---------------------------------------------------------------------------
// regfile_scan_unit
//
// Bulk-access client for the 32-entry CPU register file. Sweeps an inclusive,
// wrapping address range and either dumps registers onto an outbound
// valid/ready stream or loads them from an inbound valid/ready stream.
// Does not arbitrate: the pipeline must leave the register file alone
// while busy is high.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   start, mode         begin operation (IDLE only); 0 = dump, 1 = load
//   first_addr          first register index of the sweep
//   last_addr           last register index of the sweep (inclusive)
//   busy, done          operation in progress / one-cycle completion pulse
//   rf_read_reg         register file read port 1 address
//   rf_read_data        register file read port 1 data (combinational)
//   rf_reg_write        register file write strobe
//   rf_write_register   register file write address
//   rf_write_data       register file write data
//   out_valid/ready     dump stream handshake
//   out_data/addr/last  dumped value, its index, final-word marker
//   in_valid/ready      load stream handshake
//   in_data             value to load
// ---------------------------------------------------------------------------
module regfile_scan_unit #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              mode,
   input  logic [ADDR_W-1:0] first_addr,
   input  logic [ADDR_W-1:0] last_addr,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] rf_read_reg,
   input  logic [DATA_W-1:0] rf_read_data,
   output logic              rf_reg_write,
   output logic [ADDR_W-1:0] rf_write_register,
   output logic [DATA_W-1:0] rf_write_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_last,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data
);

   typedef enum logic [2:0] {
      IDLE, D_FETCH, D_SEND, L_RECV, L_WRITE, DONE
   } state_t;

   localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
   localparam logic [ADDR_W:0]   REM_ONE  = 1;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W:0]   remaining;   // one bit wider: a full sweep is 32 words
   logic [ADDR_W-1:0] span;
   logic              out_fire;
   logic              in_fire;

   // Modulo-32 difference gives the wrap-around length for first > last.
   assign span     = last_addr - first_addr;
   assign out_fire = out_valid && out_ready;
   assign in_fire  = in_valid && in_ready;

   assign rf_read_reg = addr;
   assign busy        = (state != IDLE);
   assign done        = (state == DONE);

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: the default at the top of a combinational block keeps every path
   // assigned, so no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = mode ? L_RECV : D_FETCH;
         D_FETCH: state_nxt = D_SEND;
         D_SEND:  if (out_fire) state_nxt = out_last ? DONE : D_FETCH;
         L_RECV:  if (in_fire) state_nxt = L_WRITE;
         L_WRITE: state_nxt = (remaining == REM_ONE) ? DONE : L_RECV;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: every datapath register is reset so an aborted sweep leaves no
   // stale strobe or stream word behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr              <= '0;
         remaining         <= '0;
         out_valid         <= 1'b0;
         out_data          <= '0;
         out_addr          <= '0;
         out_last          <= 1'b0;
         in_ready          <= 1'b0;
         rf_reg_write      <= 1'b0;
         rf_write_register <= '0;
         rf_write_data     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  addr      <= first_addr;
                  remaining <= {1'b0, span} + REM_ONE;
                  in_ready  <= mode;
               end
            end
            D_FETCH: begin
               out_data  <= rf_read_data;
               out_addr  <= addr;
               out_last  <= (remaining == REM_ONE);
               out_valid <= 1'b1;
            end
            D_SEND: begin
               // out_* hold untouched until the consumer takes the word.
               if (out_fire) begin
                  out_valid <= 1'b0;
                  addr      <= addr + ADDR_ONE;
                  remaining <= remaining - REM_ONE;
               end
            end
            L_RECV: begin
               if (in_fire) begin
                  rf_write_register <= addr;
                  rf_write_data     <= in_data;
                  rf_reg_write      <= 1'b1;
                  in_ready          <= 1'b0;
               end
            end
            L_WRITE: begin
               // Register file commits on this cycle's closing edge.
               rf_reg_write <= 1'b0;
               addr         <= addr + ADDR_ONE;
               remaining    <= remaining - REM_ONE;
               in_ready     <= (remaining != REM_ONE);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_scan_unit.sv
// ---------------------------------------------------------------------------
// tb_regfile_scan_unit
//
// Self-checking bench for regfile_scan_unit. A behavioural register file
// model sits on the rf_* ports; an independent expected-contents array plus
// plain address arithmetic predicts every stream word and write strobe.
// ---------------------------------------------------------------------------
module tb_regfile_scan_unit;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              start = 1'b0;
   logic              mode = 1'b0;
   logic [ADDR_W-1:0] first_addr = '0;
   logic [ADDR_W-1:0] last_addr = '0;
   logic              busy, done;
   logic [ADDR_W-1:0] rf_read_reg;
   logic [DATA_W-1:0] rf_read_data;
   logic              rf_reg_write;
   logic [ADDR_W-1:0] rf_write_register;
   logic [DATA_W-1:0] rf_write_data;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [DATA_W-1:0] out_data;
   logic [ADDR_W-1:0] out_addr;
   logic              out_last;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [DATA_W-1:0] in_data = '0;

   logic [DATA_W-1:0] rf     [32];
   logic [DATA_W-1:0] exp_rf [32];

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   // Register file environment: combinational read, write on posedge.
   assign rf_read_data = rf[rf_read_reg];
   always @(posedge clk) if (rf_reg_write) rf[rf_write_register] <= rf_write_data;

   regfile_scan_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
      .first_addr(first_addr), .last_addr(last_addr),
      .busy(busy), .done(done),
      .rf_read_reg(rf_read_reg), .rf_read_data(rf_read_data),
      .rf_reg_write(rf_reg_write), .rf_write_register(rf_write_register),
      .rf_write_data(rf_write_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_addr(out_addr), .out_last(out_last),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data)
   );

   function automatic logic [127:0] all_outputs();
      return 128'({busy, done, rf_read_reg, rf_reg_write, rf_write_register,
                   rf_write_data, out_valid, out_data, out_addr, out_last, in_ready});
   endfunction

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #1;
      vectors++;
      if (all_outputs() !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs got=%h want=0", all_outputs());
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_idle_busy got=%b want=0", busy);
      end
   endtask

   task automatic do_start(input logic m, input logic [ADDR_W-1:0] f, input logic [ADDR_W-1:0] l);
      @(negedge clk);
      start = 1'b1; mode = m; first_addr = f; last_addr = l;
      @(negedge clk);
      start = 1'b0; mode = 1'($urandom); first_addr = 5'($urandom); last_addr = 5'($urandom);
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL start_busy got=%b want=1", busy);
      end
   endtask

   // Called at the negedge where done is observed high.
   task automatic finish_op(input bit poke);
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL done_busy got=%b want=1", busy);
      end
      if (poke) begin
         start = 1'b1; mode = 1'($urandom); first_addr = 5'($urandom); last_addr = 5'($urandom);
      end
      @(negedge clk);
      start = 1'b0;
      vectors++;
      if ({busy, done} !== 2'b00) begin
         miscompares++;
         $display("FAIL after_done busy/done got=%b want=00", {busy, done});
      end
      @(negedge clk);
      vectors++;
      if ({busy, in_ready, out_valid} !== 3'b000) begin
         miscompares++;
         $display("FAIL idle_hold busy/in_ready/out_valid got=%b want=000",
                  {busy, in_ready, out_valid});
      end
   endtask

   task automatic run_dump(input logic [ADDR_W-1:0] f, input logic [ADDR_W-1:0] l,
                           input int pct, input int stall_at, input bit poke);
      int n, k, dn, stall, cyc;
      bit poked;
      logic pv, pr, pl;
      logic [DATA_W-1:0] pd;
      logic [ADDR_W-1:0] pa, ea;
      n = ((int'(l) - int'(f)) & 31) + 1;
      k = 0; dn = 0; stall = 0; cyc = 0; poked = 0;
      pv = 0; pr = 0; pl = 0; pd = '0; pa = '0;
      do_start(1'b0, f, l);
      while (dn == 0 && cyc < 2000) begin
         start = 1'b0;
         if (pv && !pr) begin
            vectors++;
            if ({out_valid, out_data, out_addr, out_last} !== {1'b1, pd, pa, pl}) begin
               miscompares++;
               $display("FAIL dump_hold got=%b/%h/%0d want=1/%h/%0d",
                        out_valid, out_data, out_addr, pd, pa);
            end
         end
         vectors++;
         if (rf_reg_write !== 1'b0) begin
            miscompares++;
            $display("FAIL dump_no_write got=%b want=0", rf_reg_write);
         end
         if (stall > 0) begin
            out_ready = 1'b0; stall--;
         end else begin
            out_ready = ($urandom_range(99) < pct);
         end
         if (out_valid && out_ready) begin
            ea = f + 5'(k);
            vectors++;
            if (out_addr !== ea || out_data !== exp_rf[ea] || out_last !== (k == n - 1)) begin
               miscompares++;
               $display("FAIL dump_word%0d got addr=%0d data=%h last=%b want addr=%0d data=%h last=%b",
                        k, out_addr, out_data, out_last, ea, exp_rf[ea], (k == n - 1));
            end
            k++;
            if (k == stall_at) stall = 5;
         end
         if (poke && !poked && k == 1) begin
            start = 1'b1; mode = 1'b1; first_addr = 5'($urandom); last_addr = 5'($urandom);
            poked = 1;
         end
         if (done) dn++;
         pv = out_valid; pr = out_ready; pd = out_data; pa = out_addr; pl = out_last;
         if (dn == 0) begin
            @(negedge clk);
            cyc++;
         end
      end
      out_ready = 1'b0;
      vectors++;
      if (dn == 0) begin
         miscompares++;
         $display("FAIL dump_timeout got=no_done want=done");
      end else begin
         finish_op(poke);
      end
      vectors++;
      if (k != n) begin
         miscompares++;
         $display("FAIL dump_count got=%0d want=%0d", k, n);
      end
   endtask

   task automatic run_load(input logic [ADDR_W-1:0] f, input logic [ADDR_W-1:0] l,
                           input int pct, input bit rnd, input logic [DATA_W-1:0] base,
                           input int stop_after, input bit poke);
      logic [DATA_W-1:0] w [33];
      int n, idx, ns, dn, cyc;
      bit ps, stopped, poked;
      logic [ADDR_W-1:0] ea;
      n = ((int'(l) - int'(f)) & 31) + 1;
      for (int i = 0; i < 33; i++) w[i] = rnd ? $urandom : base + DATA_W'(i);
      idx = 0; ns = 0; dn = 0; cyc = 0; ps = 0; stopped = 0; poked = 0;
      do_start(1'b1, f, l);
      while (dn == 0 && !stopped && cyc < 2000) begin
         start = 1'b0;
         if (rf_reg_write) begin
            ea = f + 5'(ns);
            vectors++;
            if (rf_write_register !== ea || rf_write_data !== w[ns] || ps) begin
               miscompares++;
               $display("FAIL load_strobe%0d got reg=%0d data=%h back2back=%b want reg=%0d data=%h",
                        ns, rf_write_register, rf_write_data, ps, ea, w[ns]);
            end
            ns++;
         end
         ps = rf_reg_write;
         if (stop_after != 0 && ns == stop_after) begin
            stopped = 1;
            in_valid = 1'b0;
         end else begin
            in_data  = w[idx];
            in_valid = ($urandom_range(99) < pct);
            if (in_valid && in_ready) begin
               exp_rf[f + 5'(idx)] = w[idx];
               idx++;
            end
            if (poke && !poked && idx == 1) begin
               start = 1'b1; mode = 1'b0; first_addr = 5'($urandom); last_addr = 5'($urandom);
               poked = 1;
            end
            if (done) dn++;
            if (dn == 0) begin
               @(negedge clk);
               cyc++;
            end
         end
      end
      in_valid = 1'b0;
      if (stopped) begin
         @(negedge clk);
         rst_n = 1'b0;
         #1;
         vectors++;
         if (all_outputs() !== '0) begin
            miscompares++;
            $display("FAIL midload_reset_outputs got=%h want=0", all_outputs());
         end
         in_valid = 1'b1;
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (rf_reg_write !== 1'b0 || in_ready !== 1'b0) begin
               miscompares++;
               $display("FAIL midload_quiet got=%b%b want=00", rf_reg_write, in_ready);
            end
         end
         rst_n = 1'b1;
         in_valid = 1'b0;
         @(negedge clk);
         vectors++;
         if ({busy, rf_reg_write} !== 2'b00) begin
            miscompares++;
            $display("FAIL midload_after got=%b want=00", {busy, rf_reg_write});
         end
         vectors++;
         if (ns != stop_after) begin
            miscompares++;
            $display("FAIL midload_strobes got=%0d want=%0d", ns, stop_after);
         end
      end else begin
         vectors++;
         if (dn == 0) begin
            miscompares++;
            $display("FAIL load_timeout got=no_done want=done");
         end else begin
            finish_op(poke);
         end
         vectors++;
         if (ns != n || idx != n) begin
            miscompares++;
            $display("FAIL load_count got strobes=%0d accepted=%0d want=%0d", ns, idx, n);
         end
      end
   endtask

   task automatic check_rf(input string tag);
      for (int i = 0; i < 32; i++) begin
         vectors++;
         if (rf[i] !== exp_rf[i]) begin
            miscompares++;
            $display("FAIL rf_%s[%0d] got=%h want=%h", tag, i, rf[i], exp_rf[i]);
         end
      end
   endtask

   task automatic test_preload();
      run_load(5'd0, 5'd31, 100, 1'b0, 32'h0, 0, 1'b0);   // RF[i] = i
      check_rf("preload");
   endtask

   task automatic test_dump_basic();
      run_dump(5'd0, 5'd3, 100, 0, 1'b0);
   endtask

   task automatic test_load_basic();
      run_load(5'd5, 5'd7, 100, 1'b0, 32'hA5A5_0001, 0, 1'b0);
      check_rf("load5_7");
      run_dump(5'd5, 5'd7, 100, 0, 1'b0);
   endtask

   task automatic test_wrap();
      run_dump(5'd30, 5'd1, 100, 0, 1'b0);
   endtask

   task automatic test_backpressure();
      run_dump(5'd8, 5'd13, 100, 2, 1'b0);
      run_load(5'd20, 5'd25, 50, 1'b1, 32'h0, 0, 1'b0);
      check_rf("toggle_load");
   endtask

   task automatic test_reset_mid_load();
      run_load(5'd10, 5'd13, 100, 1'b1, 32'h0, 2, 1'b0);
      check_rf("midload");
      run_dump(5'd9, 5'd14, 100, 0, 1'b0);
   endtask

   task automatic test_ignored_start();
      run_dump(5'd2, 5'd9, 70, 0, 1'b1);
      run_load(5'd17, 5'd19, 70, 1'b1, 32'h0, 0, 1'b1);
      check_rf("ignored_start");
      run_dump(5'd17, 5'd17, 100, 0, 1'b1);   // first == last
      run_load(5'd0, 5'd0, 100, 1'b0, 32'hDEAD_0000, 0, 1'b0);
   endtask

   task automatic test_random();
      logic [ADDR_W-1:0] f, l;
      for (int t = 0; t < 8; t++) begin
         f = 5'($urandom);
         l = f + 5'($urandom_range(11));
         if ($urandom_range(1) == 1) run_load(f, l, $urandom_range(30, 100), 1'b1, 32'h0, 0, 1'b0);
         else                        run_dump(f, l, $urandom_range(30, 100), 0, 1'b0);
      end
      check_rf("random");
      run_dump(5'd0, 5'd31, 60, 0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_preload();
      test_dump_basic();
      test_load_basic();
      test_wrap();
      test_backpressure();
      test_reset_mid_load();
      test_ignored_start();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
